// File: rtl/truth_table_sequencer_if.sv
// Bundle between the truth-table sequencer and whatever drives it.
// The master side (top level or bench) drives start/abort/expect_mask and the
// function unit's f_in. The slave side (the sequencer) drives vec and results.
//
// Handshake: start is a level sampled only while the sequencer is idle. A
// sweep begins on the first rising edge where start=1 and abort=0 in IDLE.
// There is no ready signal; start at any other time is ignored, not queued.
// Completion is a one-cycle done pulse, and the results stay valid after it.
interface truth_table_sequencer_if #(
  parameter int N_VARS = 4
);
  localparam int N_MINTERMS = 1 << N_VARS;

  logic                  start;
  logic                  abort;
  logic [N_MINTERMS-1:0] expect_mask;
  logic                  f_in;
  logic [N_VARS-1:0]     vec;
  logic                  busy;
  logic                  done;
  logic [N_MINTERMS-1:0] minterm_mask;
  logic [N_VARS:0]       ones_count;
  logic                  match;
  logic [1:0]            dbg_state;

  modport master (
    output start, abort, expect_mask, f_in,
    input  vec, busy, done, minterm_mask, ones_count, match, dbg_state
  );

  modport slave (
    input  start, abort, expect_mask, f_in,
    output vec, busy, done, minterm_mask, ones_count, match, dbg_state
  );
endinterface

// File: rtl/truth_table_sequencer.sv
// Sweeps every input vector through an external combinational function unit.
// Each vector is held for SETTLE_CYCLES cycles, then f_in is sampled into the
// minterm mask in a single SAMPLE cycle. After the last vector, the captured
// mask is compared with the expect mask latched when the sweep started.
// dbg_state exposes the FSM state: 0 IDLE, 1 SETTLE, 2 SAMPLE, 3 DONE.
module truth_table_sequencer #(
  parameter int N_VARS        = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  truth_table_sequencer_if.slave bus
);
  localparam int                N_MINTERMS  = 1 << N_VARS;
  localparam logic [N_VARS-1:0] LAST_VEC    = N_VARS'(N_MINTERMS - 1);
  localparam logic [3:0]        SETTLE_LOAD = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                state;
  logic [3:0]            settle_cnt;
  logic [N_MINTERMS-1:0] expect_q;
  logic [N_VARS-1:0]     vec_q;
  logic                  busy_q;
  logic                  done_q;
  logic [N_MINTERMS-1:0] mask_q;
  logic [N_VARS:0]       ones_q;
  logic                  match_q;

  // Mask and count as they will be once the current vector is sampled; the
  // match is taken from these so it sees the final vector's contribution.
  logic [N_MINTERMS-1:0] mask_next;
  logic [N_VARS:0]       ones_next;

  // Merge the sampled f_in into the mask at the current vector position.
  always_comb begin
    mask_next        = mask_q;
    mask_next[vec_q] = bus.f_in;
    ones_next        = ones_q + {{N_VARS{1'b0}}, bus.f_in};
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= 4'd0;
      expect_q   <= '0;
      vec_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mask_q     <= '0;
      ones_q     <= '0;
      match_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          vec_q  <= '0;
          busy_q <= 1'b0;
          // abort wins over a simultaneous start.
          if (bus.start && !bus.abort) begin
            mask_q     <= '0;
            ones_q     <= '0;
            match_q    <= 1'b0;
            expect_q   <= bus.expect_mask;
            settle_cnt <= SETTLE_LOAD;
            busy_q     <= 1'b1;
            state      <= SETTLE;
          end
        end

        SETTLE: begin
          if (bus.abort) begin
            state      <= IDLE;
            settle_cnt <= 4'd0;
            vec_q      <= '0;
            busy_q     <= 1'b0;
            mask_q     <= '0;
            ones_q     <= '0;
            match_q    <= 1'b0;
          end else begin
            // The count was loaded with SETTLE_CYCLES, so reaching 1 here
            // means this is the last settle cycle for the vector.
            settle_cnt <= settle_cnt - 4'd1;
            if (settle_cnt <= 4'd1) begin
              state <= SAMPLE;
            end
          end
        end

        SAMPLE: begin
          if (bus.abort) begin
            state      <= IDLE;
            settle_cnt <= 4'd0;
            vec_q      <= '0;
            busy_q     <= 1'b0;
            mask_q     <= '0;
            ones_q     <= '0;
            match_q    <= 1'b0;
          end else begin
            mask_q <= mask_next;
            ones_q <= ones_next;
            if (vec_q == LAST_VEC) begin
              // Terminal vector ends the sweep; vec is held, never wrapped.
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              match_q <= (mask_next == expect_q);
              state   <= DONE;
            end else begin
              vec_q      <= vec_q + 1'b1;
              settle_cnt <= SETTLE_LOAD;
              state      <= SETTLE;
            end
          end
        end

        DONE: begin
          // Results persist; only vec returns to 0 on the way back to IDLE.
          vec_q <= '0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.vec          = vec_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.minterm_mask = mask_q;
  assign bus.ones_count   = ones_q;
  assign bus.match        = match_q;
  assign bus.dbg_state    = state;
endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: two instances (3 vars / settle 1 and
// 4 vars / settle 3) share stimulus; sel picks the active one. The expected
// cycle-by-cycle behaviour is derived arithmetically from the sweep timing.
module tb_truth_table_sequencer;
  logic clk;
  logic rst_n;

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        sel;
  logic        start;
  logic        abort;
  logic [15:0] exp_in;
  logic [15:0] tt_cur;
  int          n_vars;
  int          s_cyc;

  truth_table_sequencer_if #(.N_VARS(4)) bus_a ();
  truth_table_sequencer_if #(.N_VARS(3)) bus_b ();

  truth_table_sequencer #(.N_VARS(4), .SETTLE_CYCLES(3)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  truth_table_sequencer #(.N_VARS(3), .SETTLE_CYCLES(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  // Function units: a truth table looked up by the driven vector.
  assign bus_a.f_in        = tt_cur[bus_a.vec];
  assign bus_b.f_in        = tt_cur[bus_b.vec];
  assign bus_a.start       = start & ~sel;
  assign bus_b.start       = start & sel;
  assign bus_a.abort       = abort & ~sel;
  assign bus_b.abort       = abort & sel;
  assign bus_a.expect_mask = exp_in;
  assign bus_b.expect_mask = exp_in[7:0];

  logic [15:0] o_mask;
  logic [4:0]  o_cnt;
  logic [3:0]  o_vec;
  logic        o_busy;
  logic        o_done;
  logic        o_match;

  assign o_mask  = sel ? {8'h00, bus_b.minterm_mask} : bus_a.minterm_mask;
  assign o_cnt   = sel ? {1'b0, bus_b.ones_count} : bus_a.ones_count;
  assign o_vec   = sel ? {1'b0, bus_b.vec} : bus_a.vec;
  assign o_busy  = sel ? bus_b.busy : bus_a.busy;
  assign o_done  = sel ? bus_b.done : bus_a.done;
  assign o_match = sel ? bus_b.match : bus_a.match;

  // Scoreboard.
  int n_cmp;
  int n_err;
  logic [31:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t sel=%0d)", tag, got, want, $time, sel);
    end
  endtask

  function automatic int popcount(input logic [31:0] v);
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(v[i]);
    return c;
  endfunction

  task automatic check_cleared(input string tag);
    check_val({tag, " busy"},  32'(o_busy), 32'd0);
    check_val({tag, " done"},  32'(o_done), 32'd0);
    check_val({tag, " vec"},   32'(o_vec), 32'd0);
    check_val({tag, " mask"},  32'(o_mask), 32'd0);
    check_val({tag, " count"}, 32'(o_cnt), 32'd0);
    check_val({tag, " match"}, 32'(o_match), 32'd0);
  endtask

  // One sweep. abort_k / rst_k (>=0) interrupt the sweep by asserting abort
  // or rst_n=0 during cycle k after the accepting edge; noise pulses start
  // while the sweep runs.
  task automatic run_sweep(input logic [15:0] tt_in, input logic [15:0] ex_in,
                           input int abort_k, input int rst_k, input bit noise);
    int          n_min = 1 << n_vars;
    int          t     = n_min * (s_cyc + 1);
    logic [31:0] full  = (32'd1 << n_min) - 32'd1;
    logic [31:0] tt    = {16'h0, tt_in} & full;
    logic [31:0] ex    = {16'h0, ex_in} & full;
    bit          intr  = 1'b0;
    tt_cur = tt[15:0];
    exp_in = ex_in;
    start  = 1'b1;
    abort  = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k <= t + 1; k++) begin
      int          m;
      logic [31:0] part;
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (intr) begin
        abort = 1'b0;
        rst_n = 1'b1;
        start = 1'b0;
        check_cleared("interrupt");
        for (int j = 0; j < t; j++) begin
          @(posedge clk); #1;
          check_val("post-interrupt done", 32'(o_done), 32'd0);
          check_val("post-interrupt busy", 32'(o_busy), 32'd0);
        end
        return;
      end
      m    = (k < t) ? k / (s_cyc + 1) : n_min;
      part = tt & ((32'd1 << m) - 32'd1);
      check_val("busy",  32'(o_busy), (k < t) ? 32'd1 : 32'd0);
      check_val("done",  32'(o_done), (k == t) ? 32'd1 : 32'd0);
      check_val("vec",   32'(o_vec),
                (k < t) ? 32'(k / (s_cyc + 1)) : ((k == t) ? 32'(n_min - 1) : 32'd0));
      check_val("mask",  32'(o_mask), part);
      check_val("count", 32'(o_cnt), 32'(popcount(part)));
      check_val("match", 32'(o_match), (k >= t && tt == ex) ? 32'd1 : 32'd0);
      start = noise && (k <= t) && ($urandom_range(0, 3) == 0);
      if (k == abort_k) begin
        abort = 1'b1;
        intr  = 1'b1;
      end
      if (k == rst_k) begin
        rst_n = 1'b0;
        intr  = 1'b1;
      end
    end
    start = 1'b0;
  endtask

  task automatic use_cfg(input bit b);
    sel    = b;
    n_vars = b ? 3 : 4;
    s_cyc  = b ? 1 : 3;
  endtask

  initial begin
    logic [15:0] tt_yz;
    logic [15:0] tt_z;
    logic [15:0] held_mask;
    n_cmp  = 0;
    n_err  = 0;
    start  = 1'b0;
    abort  = 1'b0;
    exp_in = 16'h0;
    tt_cur = 16'h0;
    use_cfg(1'b0);
    rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset a");
    use_cfg(1'b1);
    #1;
    check_cleared("reset b");
    rst_n = 1'b1;

    // Three-variable exercises: y^z and z (vec bit 2 is x).
    tt_yz = 16'h0;
    tt_z  = 16'h0;
    for (int i = 0; i < 8; i++) begin
      tt_yz[i] = ((i >> 1) & 1) != (i & 1);
      tt_z[i]  = (i & 1) != 0;
    end
    exp_q.push_back(32'h66);
    exp_q.push_back(32'hAA);
    check_val("tt y^z", {16'h0, tt_yz}, exp_q.pop_front());
    check_val("tt z", {16'h0, tt_z}, exp_q.pop_front());
    run_sweep(tt_yz, 16'h0066, -1, -1, 1'b0);
    run_sweep(tt_z, 16'h0066, -1, -1, 1'b0);
    held_mask = o_mask;

    // start+abort together in IDLE, then abort alone: nothing changes.
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("start+abort busy", 32'(o_busy), 32'd0);
    check_val("start+abort mask", 32'(o_mask), {16'h0, held_mask});
    @(posedge clk); #1;
    abort = 1'b0;
    check_val("idle abort busy", 32'(o_busy), 32'd0);
    check_val("idle abort mask", 32'(o_mask), {16'h0, held_mask});
    check_val("idle abort count", 32'(o_cnt), 32'd4);

    // Four-variable, settle 3: minterms {0,1,6,9,11} with start noise.
    use_cfg(1'b0);
    @(posedge clk); #1;
    run_sweep(16'h0A43, 16'h0A43, -1, -1, 1'b1);
    run_sweep(16'h0A43, 16'h0A43, 5 * 4 + $urandom_range(0, 3), -1, 1'b0);
    run_sweep(16'h0A43, 16'h0A43, -1, -1, 1'b0);
    run_sweep(16'hBEEF, 16'h0, -1, 4 * $urandom_range(0, 15) + $urandom_range(0, 2), 1'b0);
    run_sweep(16'hFFFF, 16'hFFFF, -1, -1, 1'b0);
    check_val("all ones count", 32'(o_cnt), 32'd16);

    // Randomized sweeps on both configurations.
    for (int r = 0; r < 12; r++) begin
      logic [15:0] tt_r;
      logic [15:0] ex_r;
      int          ab;
      use_cfg(r[0]);
      @(posedge clk); #1;
      tt_r = 16'($urandom);
      ex_r = ($urandom_range(0, 1) == 1) ? tt_r : 16'($urandom);
      ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, (1 << n_vars) * (s_cyc + 1) - 1) : -1;
      run_sweep(tt_r, ex_r, ab, -1, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/truth_table_sequencer.md
Name: truth_table_sequencer

Overview:
- Sequencer that sweeps every input combination through an external combinational sum-of-products function unit, one vector at a time.
- Waits a programmable settle time per vector, then samples the unit's output into a minterm mask and counts the ones.
- Compares the captured mask against an expected mask and flags the result.
- Sits between the exercise function units and the testbench/top level, and is the single driver of their inputs.

Parameters:
- N_VARS, 4, number of function inputs; legal range 2..5; vec bit N_VARS-1 is the leftmost variable (x).
- SETTLE_CYCLES, 1, cycles the vector is held before sampling; legal range 1..15.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- start  input  1  request a sweep; sampled only in IDLE.
- abort  input  1  synchronous cancel of a running sweep.
- expect_mask  input  2**N_VARS  expected minterm mask; sampled at start acceptance.
- f_in  input  1  output of the function unit under sequencing.
- vec  output  N_VARS  input vector driven to the function unit.
- busy  output  1  high in SETTLE and SAMPLE.
- done  output  1  one-cycle pulse when a sweep completes.
- minterm_mask  output  2**N_VARS  bit i = f_in sampled while vec==i.
- ones_count  output  N_VARS+1  number of set bits in minterm_mask.
- match  output  1  minterm_mask == latched expect_mask; valid from the done cycle onward.

Behaviour:
- Reset (rst_n low at edge):
  - State returns to IDLE.
  - vec, busy, done, minterm_mask, ones_count and match all go to 0.
  - Internal expect register and settle counter are cleared.
  - Reset mid-sweep behaves identically.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - vec=0, busy=0.
  - On start=1 and abort=0: vec<=0, minterm_mask<=0, ones_count<=0, match<=0, latch expect_mask, wait counter<=SETTLE_CYCLES, go to SETTLE.
  - Otherwise outputs hold the previous results.
- SETTLE:
  - busy=1; vec is stable.
  - Counter decrements each cycle; after exactly SETTLE_CYCLES cycles, go to SAMPLE.
- SAMPLE (one cycle):
  - minterm_mask[vec]<=f_in; ones_count<=ones_count+f_in.
  - If vec==2**N_VARS-1: go to DONE.
  - Else: vec<=vec+1, counter<=SETTLE_CYCLES, go to SETTLE.
- DONE (one cycle):
  - done=1, busy=0, match valid; then go to IDLE.
  - vec returns to 0 on entry to IDLE.
- Timing:
  - Per vector: SETTLE_CYCLES+1 cycles.
  - done is high for exactly the one cycle that begins 2**N_VARS*(SETTLE_CYCLES+1) edges after the edge accepting start.
- start while busy or in DONE: ignored; no queuing.
- abort in SETTLE/SAMPLE:
  - Next edge goes to IDLE; no done pulse.
  - minterm_mask, ones_count and match are cleared to 0.
- abort in IDLE or DONE: no effect beyond the normal flow.
- start and abort together in IDLE: abort wins; stay in IDLE.
- Width rules:
  - ones_count cannot overflow; its maximum is 2**N_VARS, which fits in N_VARS+1 bits.
  - vec never wraps: the terminal vector always ends the sweep.
- Result persistence: minterm_mask, ones_count and match hold after DONE until the next accepted start, abort, or reset.

Test Plan:
- N_VARS=3, S=1, f_in = y^z (3-var exercise a), expect_mask=8'h66 -> done exactly 16 edges after start; minterm_mask=8'h66, ones_count=4, match=1.
- N_VARS=3, S=1, f_in = z, expect_mask=8'h66 -> minterm_mask=8'hAA, ones_count=4, match=0; vec sequence 0..7, each held 2 cycles.
- N_VARS=4, S=3, function with minterms {0,1,6,9,11} -> minterm_mask=16'h0A43, ones_count=5, done 64 edges after start, busy high for 64 cycles.
- Assert abort during vec==5 of a 4-var sweep -> IDLE next edge, no done, mask/count=0; a new start gives a correct full sweep.
- Pulse start while busy, and start+abort together in IDLE -> no restart and no state change respectively; the running sweep's done timing is unaffected.
- Drive rst_n low for one edge mid-SETTLE -> all outputs 0 and IDLE next cycle; f_in held at 1 for a whole sweep -> mask all ones, ones_count=2**N_VARS (16 for N=4).
